mips_program_loader: RTL and testbench



---
 rtl/mips_loader_pkg.sv | 24 ++
 rtl/mips_program_loader_packer.sv | 42 ++++
 rtl/mips_program_loader.sv | 156 +++++++++++++++
 tb/tb_mips_program_loader.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_loader_pkg.sv
// Shared types and constants for the MIPS program loader.
// Frame: A5, LEN_HI, LEN_LO, N*4 data bytes (MSB first), XOR checksum.
package mips_loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         LEN_W     = 16;

  typedef enum logic [2:0] {
    ST_SYNC,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } loader_state_t;

  function automatic logic is_rx_state(
    input loader_state_t s
  );
    return (s != ST_DONE) && (s != ST_ERROR);
  endfunction

endpackage

// File: rtl/mips_program_loader_packer.sv
// Four-byte MSB-first word assembler.
// word/word_valid are registered on the 4th byte.
module byte_word_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_valid,
  output logic [1:0]  byte_idx
);

  logic [23:0] sr;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      sr         <= '0;
      byte_idx   <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (shift_en) begin
        sr       <= {sr[15:0], byte_in};
        byte_idx <= byte_idx + 2'd1;
        if (byte_idx == 2'd3) begin
          word_valid <= 1'b1;
        end
      end
    end
  end

  // Output word is held between writes, so only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      word <= '0;
    end else if (shift_en && byte_idx == 2'd3) begin
      word <= {sr, byte_in};
    end
  end

endmodule

// File: rtl/mips_program_loader.sv
// Byte-stream loader for MIPS instruction memory.
// Keeps the CPU in reset until a checksummed image is written.
module mips_program_loader
  import mips_loader_pkg::*;
#(
  parameter int          ADDR_WIDTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  input  logic        restart,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_reset,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);

  localparam logic [31:0] CAP = 32'd1 << ADDR_WIDTH;

  loader_state_t    state_q, state_n;
  logic [7:0]       len_hi_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] len_in;
  logic [7:0]       chk_q;
  logic [1:0]       byte_idx;
  logic             hs;
  logic             sync_hit;
  logic             word_end;
  logic             last_word;
  logic             rx_ready_n;
  logic             done_n;
  logic             error_n;
  logic             cpu_reset_n;

  assign hs        = rx_valid & rx_ready;
  assign len_in    = {len_hi_q, rx_data};
  assign sync_hit  = hs && state_q == ST_SYNC
                     && rx_data == SYNC_BYTE;
  assign word_end  = hs && state_q == ST_DATA
                     && byte_idx == 2'd3;
  assign last_word = words_loaded == len_q - 16'd1;

  byte_word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (sync_hit),
    .shift_en   (hs && state_q == ST_DATA),
    .byte_in    (rx_data),
    .word       (imem_wdata),
    .word_valid (imem_we),
    .byte_idx   (byte_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_SYNC;
    else       state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      ST_SYNC:
        if (sync_hit) state_n = ST_LEN_HI;
      ST_LEN_HI:
        if (hs) state_n = ST_LEN_LO;
      ST_LEN_LO:
        if (hs) begin
          if ({16'd0, len_in} > CAP)
            state_n = ST_ERROR;
          else if (len_in == '0)
            state_n = ST_CHECK;
          else
            state_n = ST_DATA;
        end
      ST_DATA:
        if (word_end && last_word)
          state_n = ST_CHECK;
      ST_CHECK:
        if (hs) begin
          state_n = (rx_data == chk_q)
                    ? ST_DONE : ST_ERROR;
        end
      ST_DONE, ST_ERROR:
        if (restart) state_n = ST_SYNC;
      default:
        state_n = ST_SYNC;
    endcase
  end

  // Status flags follow the state being entered, so they
  // change on the same edge as the state itself.
  always_comb begin
    rx_ready_n  = is_rx_state(state_n);
    done_n      = state_n == ST_DONE;
    error_n     = state_n == ST_ERROR;
    cpu_reset_n = state_n != ST_DONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_ready  <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      cpu_reset <= 1'b1;
    end else begin
      rx_ready  <= rx_ready_n;
      done      <= done_n;
      error     <= error_n;
      cpu_reset <= cpu_reset_n;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      len_hi_q     <= '0;
      len_q        <= '0;
      chk_q        <= '0;
      words_loaded <= '0;
      imem_addr    <= '0;
    end else begin
      if ((state_q == ST_DONE || state_q == ST_ERROR)
          && restart) begin
        words_loaded <= '0;
      end
      if (sync_hit) chk_q <= '0;
      if (hs) begin
        case (state_q)
          ST_LEN_HI: begin
            len_hi_q <= rx_data;
            chk_q    <= chk_q ^ rx_data;
          end
          ST_LEN_LO: begin
            len_q <= len_in;
            chk_q <= chk_q ^ rx_data;
          end
          ST_DATA: begin
            chk_q <= chk_q ^ rx_data;
          end
          default: ;
        endcase
      end
      if (word_end) begin
        imem_addr    <= BASE_ADDR
                        + {14'd0, words_loaded, 2'b00};
        words_loaded <= words_loaded + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_mips_program_loader.sv
// Directed bench for mips_program_loader.
// Frames and checksums are hand-computed.
module tb_mips_program_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        restart = 1'b0;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_reset;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  int checks = 0;
  int failures = 0;
  int wcount = 0;
  int wbase;
  logic [31:0] prog [3];

  mips_program_loader #(
    .ADDR_WIDTH (8),
    .BASE_ADDR  (32'h0000_0000)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .restart      (restart),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_reset    (cpu_reset),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we === 1'b1) wcount++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b,
                           input int gap);
    int n;
    n = 0;
    rx_valid = 1'b0;
    repeat (gap) tick();
    rx_valid = 1'b1;
    rx_data  = b;
    while (rx_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("rx_ready_timeout",
                       {31'd0, rx_ready}, 32'd1);
    else tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w,
                           input int k,
                           input int gap);
    for (int i = 3; i >= 0; i--)
      send_byte(w[8*i +: 8], gap);
    check("we_pulse", {31'd0, imem_we}, 32'd1);
    check("wr_addr", imem_addr, 32'(4 * k));
    check("wr_data", imem_wdata, w);
  endtask

  task automatic send_frame1(input logic [7:0] chk,
                             input int gap);
    send_byte(8'hA5, gap);
    send_byte(8'h00, gap);
    send_byte(8'h03, gap);
    for (int k = 0; k < 3; k++)
      send_word(prog[k], k, (gap + k) % 3);
    send_byte(chk, gap);
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    tick();
    restart = 1'b0;
  endtask

  initial begin
    prog[0] = 32'h2008_0005;
    prog[1] = 32'h2009_0003;
    prog[2] = 32'h0109_5020;

    repeat (3) tick();
    check("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
    check("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_we", {31'd0, imem_we}, 32'd0);
    check("rst_addr", imem_addr, 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_words", {16'd0, words_loaded}, 32'd0);
    reset = 1'b0;
    tick();
    check("ready_after_rst", {31'd0, rx_ready}, 32'd1);

    // 1: good frame
    wbase = wcount;
    send_frame1(8'h7C, 0);
    check("t1_done", {31'd0, done}, 32'd1);
    check("t1_error", {31'd0, error}, 32'd0);
    check("t1_cpu_reset", {31'd0, cpu_reset}, 32'd0);
    check("t1_rx_ready", {31'd0, rx_ready}, 32'd0);
    check("t1_words", {16'd0, words_loaded}, 32'd3);
    check("t1_wcount", 32'(wcount - wbase), 32'd3);
    repeat (3) tick();
    check("t1_hold_done", {31'd0, done}, 32'd1);

    // 2: bad checksum, then restart
    pulse_restart();
    check("t2_rs_done", {31'd0, done}, 32'd0);
    check("t2_rs_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("t2_rs_words", {16'd0, words_loaded}, 32'd0);
    wbase = wcount;
    send_frame1(8'h7D, 0);
    check("t2_error", {31'd0, error}, 32'd1);
    check("t2_done", {31'd0, done}, 32'd0);
    check("t2_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("t2_rx_ready", {31'd0, rx_ready}, 32'd0);
    check("t2_wcount", 32'(wcount - wbase), 32'd3);
    pulse_restart();
    check("t2_rs_error", {31'd0, error}, 32'd0);
    check("t2_rs_ready", {31'd0, rx_ready}, 32'd1);

    // 3: empty image
    wbase = wcount;
    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    tick();
    check("t3_done", {31'd0, done}, 32'd1);
    check("t3_cpu_reset", {31'd0, cpu_reset}, 32'd0);
    check("t3_words", {16'd0, words_loaded}, 32'd0);
    check("t3_wcount", 32'(wcount - wbase), 32'd0);
    pulse_restart();

    // 4: oversize N=257
    wbase = wcount;
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    check("t4_error", {31'd0, error}, 32'd1);
    check("t4_rx_ready", {31'd0, rx_ready}, 32'd0);
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    repeat (3) tick();
    rx_valid = 1'b0;
    check("t4_still_blocked", {31'd0, rx_ready}, 32'd0);
    check("t4_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("t4_wcount", 32'(wcount - wbase), 32'd0);
    pulse_restart();
    check("t4_rs_error", {31'd0, error}, 32'd0);

    // 5: garbage prefix and gaps
    wbase = wcount;
    send_byte(8'h12, 2);
    send_byte(8'hFF, 1);
    check("t5_garbage_ready", {31'd0, rx_ready}, 32'd1);
    send_frame1(8'h7C, 1);
    check("t5_done", {31'd0, done}, 32'd1);
    check("t5_words", {16'd0, words_loaded}, 32'd3);
    check("t5_wcount", 32'(wcount - wbase), 32'd3);
    pulse_restart();

    // 6: reset in middle of word 1
    wbase = wcount;
    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    send_word(prog[0], 0, 0);
    send_byte(8'h20, 0);
    send_byte(8'h09, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("t6_words", {16'd0, words_loaded}, 32'd0);
    repeat (3) tick();
    check("t6_no_partial", 32'(wcount - wbase), 32'd1);
    check("t6_ready", {31'd0, rx_ready}, 32'd1);
    send_frame1(8'h7C, 0);
    check("t6_done", {31'd0, done}, 32'd1);
    check("t6_cpu_run", {31'd0, cpu_reset}, 32'd0);
    check("t6_wcount", 32'(wcount - wbase), 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
